// File: rtl/mbinit_repairval_pkg.sv
// Shared sideband message codes, LTSM timeout constants and request-tag helpers
// for the MBINIT.REPAIRVAL requester.
package mbinit_repairval_pkg;

    localparam logic [3:0] MSG_NONE        = 4'd0;
    localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
    localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
    localparam logic [3:0] MSG_RESULT_REQ  = 4'd3;
    localparam logic [3:0] MSG_RESULT_RESP = 4'd4;
    localparam logic [3:0] MSG_DONE_REQ    = 4'd5;
    localparam logic [3:0] MSG_DONE_RESP   = 4'd6;

    // 8 ms at 100 MHz
    localparam int LTSM_TIMEOUT_CYCLES = 800000;
    localparam int LTSM_CNT_W          = 20;

    localparam logic [1:0] TAG_INIT   = 2'd0;
    localparam logic [1:0] TAG_RESULT = 2'd1;
    localparam logic [1:0] TAG_DONE   = 2'd2;

    function automatic logic [3:0] resp_code(input logic [1:0] tag);
        case (tag)
            TAG_INIT:   resp_code = MSG_INIT_RESP;
            TAG_RESULT: resp_code = MSG_RESULT_RESP;
            TAG_DONE:   resp_code = MSG_DONE_RESP;
            default:    resp_code = MSG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mbinit_repairval.sv
// MBINIT.REPAIRVAL requester: sideband init/result/done handshakes, VALTRAIN run,
// partner-result evaluation with one redundant-valid repair; outputs registered from next state.
module mbinit_repairval
    import mbinit_repairval_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LTSM_TIMEOUT_CYCLES,
    parameter int CNT_W          = LTSM_CNT_W
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       i_REPAIRCLK_end,
    input  logic [3:0] i_Rx_SbMessage,
    input  logic       i_msg_valid,
    input  logic       i_Busy_SideBand,
    input  logic       i_falling_edge_busy,
    input  logic       i_ValPattern_done,
    input  logic       i_Repair_done,
    input  logic [1:0] i_REPAIRVAL_Result,
    output logic       o_ValPattern_En,
    output logic       o_ApplyRepair_En,
    output logic [3:0] o_TX_SbMessage,
    output logic       o_ValidOutData,
    output logic       o_REPAIRVAL_end,
    output logic       o_train_error_req
);

    localparam logic [3:0] ST_IDLE            = 4'd0;
    localparam logic [3:0] ST_INIT_REQ        = 4'd1;
    localparam logic [3:0] ST_RESULT_REQ      = 4'd2;
    localparam logic [3:0] ST_DONE_REQ        = 4'd3;
    localparam logic [3:0] ST_WAIT_RESP       = 4'd4;
    localparam logic [3:0] ST_VAL_PATTERN     = 4'd5;
    localparam logic [3:0] ST_CHK_BUSY_RESULT = 4'd6;
    localparam logic [3:0] ST_CHK_BUSY_DONE   = 4'd7;
    localparam logic [3:0] ST_CHECK_RESULT    = 4'd8;
    localparam logic [3:0] ST_APPLY_REPAIR    = 4'd9;
    localparam logic [3:0] ST_DONE            = 4'd10;
    localparam logic [3:0] ST_ERROR           = 4'd11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       cs, ns;
    logic [1:0]       tag;
    logic             repaired;
    logic [CNT_W-1:0] cnt;
    logic             cs_req, cs_timed, timeout;
    logic             ns_req;
    logic [3:0]       ns_tx_code;

    assign cs_req   = (cs == ST_INIT_REQ) || (cs == ST_RESULT_REQ) || (cs == ST_DONE_REQ);
    assign cs_timed = cs_req || (cs == ST_WAIT_RESP);
    assign timeout  = cs_timed && (cnt >= CNT_LAST);
    assign ns_req   = (ns == ST_INIT_REQ) || (ns == ST_RESULT_REQ) || (ns == ST_DONE_REQ);

    always_comb begin
        ns = cs;
        case (cs)
            ST_IDLE:            if (i_REPAIRCLK_end && !i_Busy_SideBand) ns = ST_INIT_REQ;
            ST_INIT_REQ,
            ST_RESULT_REQ,
            ST_DONE_REQ:        if (i_falling_edge_busy) ns = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (i_msg_valid && (i_Rx_SbMessage == resp_code(tag))) begin
                    case (tag)
                        TAG_INIT:   ns = ST_VAL_PATTERN;
                        TAG_RESULT: ns = ST_CHECK_RESULT;
                        TAG_DONE:   ns = ST_DONE;
                        default:    ns = ST_IDLE;
                    endcase
                end
            end
            ST_VAL_PATTERN:     if (i_ValPattern_done) ns = ST_CHK_BUSY_RESULT;
            ST_CHK_BUSY_RESULT: if (!i_Busy_SideBand) ns = ST_RESULT_REQ;
            ST_CHK_BUSY_DONE:   if (!i_Busy_SideBand) ns = ST_DONE_REQ;
            ST_CHECK_RESULT: begin
                if (i_REPAIRVAL_Result[0])                   ns = ST_CHK_BUSY_DONE;
                else if (i_REPAIRVAL_Result[1] && !repaired) ns = ST_APPLY_REPAIR;
                else                                         ns = ST_ERROR;
            end
            ST_APPLY_REPAIR:    if (i_Repair_done) ns = ST_CHK_BUSY_DONE;
            ST_DONE, ST_ERROR:  ns = cs;
            default:            ns = ST_IDLE;
        endcase
        // Timeout overrides a same-cycle response; enable drop overrides everything.
        if (timeout)          ns = ST_ERROR;
        if (!i_REPAIRCLK_end) ns = ST_IDLE;
    end

    always_comb begin
        ns_tx_code = MSG_NONE;
        case (ns)
            ST_INIT_REQ:   ns_tx_code = MSG_INIT_REQ;
            ST_RESULT_REQ: ns_tx_code = MSG_RESULT_REQ;
            ST_DONE_REQ:   ns_tx_code = MSG_DONE_REQ;
            default:       ns_tx_code = MSG_NONE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cs       <= ST_IDLE;
            tag      <= TAG_INIT;
            repaired <= 1'b0;
            cnt      <= '0;
        end else begin
            cs <= ns;
            if (ns == ST_WAIT_RESP && cs != ST_WAIT_RESP) begin
                case (cs)
                    ST_RESULT_REQ: tag <= TAG_RESULT;
                    ST_DONE_REQ:   tag <= TAG_DONE;
                    default:       tag <= TAG_INIT;
                endcase
            end
            if (cs == ST_IDLE)
                repaired <= 1'b0;
            else if (cs == ST_APPLY_REPAIR && ns == ST_CHK_BUSY_DONE)
                repaired <= 1'b1;
            if (ns_req && ns != cs)
                cnt <= '0;
            else if (cs_timed && cnt < CNT_LAST)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            o_ValPattern_En   <= 1'b0;
            o_ApplyRepair_En  <= 1'b0;
            o_TX_SbMessage    <= MSG_NONE;
            o_ValidOutData    <= 1'b0;
            o_REPAIRVAL_end   <= 1'b0;
            o_train_error_req <= 1'b0;
        end else begin
            o_ValPattern_En   <= (ns == ST_VAL_PATTERN);
            o_ApplyRepair_En  <= (ns == ST_APPLY_REPAIR);
            o_TX_SbMessage    <= ns_tx_code;
            o_ValidOutData    <= ns_req;
            o_REPAIRVAL_end   <= (ns == ST_DONE);
            o_train_error_req <= (ns == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_mbinit_repairval.sv
// Scoreboard bench for mbinit_repairval: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT raises its outputs.
module tb_mbinit_repairval;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       i_REPAIRCLK_end;
    logic [3:0] i_Rx_SbMessage;
    logic       i_msg_valid;
    logic       i_Busy_SideBand;
    logic       i_falling_edge_busy;
    logic       i_ValPattern_done;
    logic       i_Repair_done;
    logic [1:0] i_REPAIRVAL_Result;
    logic       o_ValPattern_En;
    logic       o_ApplyRepair_En;
    logic [3:0] o_TX_SbMessage;
    logic       o_ValidOutData;
    logic       o_REPAIRVAL_end;
    logic       o_train_error_req;

    localparam logic [7:0] EV_TX  = 8'h10;
    localparam logic [7:0] EV_PAT = 8'h20;
    localparam logic [7:0] EV_REP = 8'h30;
    localparam logic [7:0] EV_END = 8'h40;
    localparam logic [7:0] EV_ERR = 8'h50;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    mbinit_repairval #(.TIMEOUT_CYCLES(16), .CNT_W(20)) dut (
        .CLK                 (CLK),
        .rst_n               (rst_n),
        .i_REPAIRCLK_end     (i_REPAIRCLK_end),
        .i_Rx_SbMessage      (i_Rx_SbMessage),
        .i_msg_valid         (i_msg_valid),
        .i_Busy_SideBand     (i_Busy_SideBand),
        .i_falling_edge_busy (i_falling_edge_busy),
        .i_ValPattern_done   (i_ValPattern_done),
        .i_Repair_done       (i_Repair_done),
        .i_REPAIRVAL_Result  (i_REPAIRVAL_Result),
        .o_ValPattern_En     (o_ValPattern_En),
        .o_ApplyRepair_En    (o_ApplyRepair_En),
        .o_TX_SbMessage      (o_TX_SbMessage),
        .o_ValidOutData      (o_ValidOutData),
        .o_REPAIRVAL_end     (o_REPAIRVAL_end),
        .o_train_error_req   (o_train_error_req)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every rising output is an event that must match the queue head.
    task automatic observe(input logic [7:0] obs);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %0h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            if (e !== obs) begin
                errors++;
                $display("FAIL event_order: got %0h expected %0h", obs, e);
            end
        end
    endtask

    initial begin
        logic pv = 1'b0, pp = 1'b0, pa = 1'b0, pe = 1'b0, pr = 1'b0;
        forever begin
            @(negedge CLK);
            if (rst_n === 1'b1) begin
                if (o_ValidOutData && !pv)    observe(EV_TX | {4'h0, o_TX_SbMessage});
                if (o_ValPattern_En && !pp)   observe(EV_PAT);
                if (o_ApplyRepair_En && !pa)  observe(EV_REP);
                if (o_REPAIRVAL_end && !pe)   observe(EV_END);
                if (o_train_error_req && !pr) observe(EV_ERR);
            end
            pv = o_ValidOutData;
            pp = o_ValPattern_En;
            pa = o_ApplyRepair_En;
            pe = o_REPAIRVAL_end;
            pr = o_train_error_req;
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (o_ValidOutData !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(name, o_ValidOutData, 1);
    endtask

    // Sideband TX: busy for two cycles, then the falling-edge pulse.
    task automatic sb_send;
        i_Busy_SideBand = 1'b1;
        tick();
        tick();
        i_Busy_SideBand     = 1'b0;
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
    endtask

    task automatic do_req(input logic [3:0] code, input string name);
        exp_q.push_back(EV_TX | {4'h0, code});
        wait_valid(name);
        sb_send();
    endtask

    task automatic resp(input logic [3:0] code);
        i_Rx_SbMessage = code;
        i_msg_valid    = 1'b1;
        tick();
        i_msg_valid    = 1'b0;
        i_Rx_SbMessage = 4'd0;
    endtask

    task automatic pattern_done;
        i_ValPattern_done = 1'b1;
        tick();
        i_ValPattern_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valpat"}, o_ValPattern_En, 0);
        chk({tag, "_apply"},  o_ApplyRepair_En, 0);
        chk({tag, "_tx"},     o_TX_SbMessage, 0);
        chk({tag, "_valid"},  o_ValidOutData, 0);
        chk({tag, "_end"},    o_REPAIRVAL_end, 0);
        chk({tag, "_err"},    o_train_error_req, 0);
    endtask

    task automatic disable_and_check(input string tag);
        i_REPAIRCLK_end = 1'b0;
        tick();
        check_all_zero(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n               = 1'b0;
        i_REPAIRCLK_end     = 1'b0;
        i_Rx_SbMessage      = 4'd0;
        i_msg_valid         = 1'b0;
        i_Busy_SideBand     = 1'b0;
        i_falling_edge_busy = 1'b0;
        i_ValPattern_done   = 1'b0;
        i_Repair_done       = 1'b0;
        i_REPAIRVAL_Result  = 2'b00;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Happy path: tx 1,3,5 then end one cycle after done_resp.
        i_REPAIRCLK_end = 1'b1;
        do_req(4'd1, "happy_init_valid");
        chk("happy_init_wait_pat", o_ValPattern_En, 0);
        exp_q.push_back(EV_PAT);
        resp(4'd2);
        chk("happy_pattern_en", o_ValPattern_En, 1);
        pattern_done();
        do_req(4'd3, "happy_result_valid");
        i_REPAIRVAL_Result = 2'b01;
        resp(4'd4);
        do_req(4'd5, "happy_done_valid");
        chk("happy_end_before_resp", o_REPAIRVAL_end, 0);
        exp_q.push_back(EV_END);
        resp(4'd6);
        chk("happy_end_after_resp", o_REPAIRVAL_end, 1);
        tick();
        chk("happy_end_held", o_REPAIRVAL_end, 1);
        disable_and_check("happy_off");

        // Repair: TVLD fails, RVLD passes.
        i_REPAIRCLK_end = 1'b1;
        do_req(4'd1, "rep_init_valid");
        exp_q.push_back(EV_PAT);
        resp(4'd2);
        pattern_done();
        do_req(4'd3, "rep_result_valid");
        i_REPAIRVAL_Result = 2'b10;
        exp_q.push_back(EV_REP);
        resp(4'd4);
        n = 0;
        while (o_ApplyRepair_En !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("rep_apply_en", o_ApplyRepair_En, 1);
        tick();
        tick();
        chk("rep_apply_held", o_ApplyRepair_En, 1);
        chk("rep_no_tx_yet", o_ValidOutData, 0);
        i_Repair_done = 1'b1;
        tick();
        i_Repair_done = 1'b0;
        chk("rep_apply_dropped", o_ApplyRepair_En, 0);
        do_req(4'd5, "rep_done_valid");
        exp_q.push_back(EV_END);
        resp(4'd6);
        chk("rep_end", o_REPAIRVAL_end, 1);
        disable_and_check("rep_off");

        // Both lanes fail: error, no done_req.
        i_REPAIRCLK_end = 1'b1;
        do_req(4'd1, "fail_init_valid");
        exp_q.push_back(EV_PAT);
        resp(4'd2);
        pattern_done();
        do_req(4'd3, "fail_result_valid");
        i_REPAIRVAL_Result = 2'b00;
        exp_q.push_back(EV_ERR);
        resp(4'd4);
        repeat (3) tick();
        chk("fail_err", o_train_error_req, 1);
        chk("fail_no_tx", o_ValidOutData, 0);
        chk("fail_no_end", o_REPAIRVAL_end, 0);
        disable_and_check("fail_off");

        // Timeout: no init_resp, error 16 cycles after INIT_REQ entry.
        i_REPAIRCLK_end = 1'b1;
        exp_q.push_back(EV_TX | 8'h01);
        wait_valid("to_init_valid");
        exp_q.push_back(EV_ERR);
        n = 0;
        while (o_train_error_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("to_err", o_train_error_req, 1);
        chk("to_cycles", n, 16);
        disable_and_check("to_off");

        // Abort mid VAL_PATTERN, restart, then a wrong response is ignored.
        i_REPAIRCLK_end = 1'b1;
        do_req(4'd1, "ab_init_valid");
        exp_q.push_back(EV_PAT);
        resp(4'd2);
        chk("ab_pattern_en", o_ValPattern_En, 1);
        i_REPAIRCLK_end = 1'b0;
        tick();
        chk("ab_pattern_off", o_ValPattern_En, 0);
        chk("ab_valid_off", o_ValidOutData, 0);
        i_REPAIRCLK_end = 1'b1;
        do_req(4'd1, "ab_restart_valid");
        resp(4'd6);
        tick();
        chk("wrong_resp_no_pat", o_ValPattern_En, 0);
        chk("wrong_resp_no_end", o_REPAIRVAL_end, 0);
        exp_q.push_back(EV_PAT);
        resp(4'd2);
        chk("wrong_resp_then_pat", o_ValPattern_En, 1);
        disable_and_check("ab_off");

        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
